demux_1to2_buffered: RTL and testbench
======================================

Name: demux_1to2_buffered

Overview:
- Registered 1-to-2 demultiplexer with per-output buffering; the complement of the 2-to-1 select mux.
- Steers a 32-bit word from one producer to one of two consumers, chosen by `select`.
- Example use: write-back or bus path routing one result stream to two destinations (e.g. data memory vs. register file).
- Each destination has its own FIFO with a valid/ready handshake, so one stalled consumer does not corrupt the other's stream.

Parameters:
- WIDTH, 32: data width of the input and both outputs.
- DEPTH, 4: entries per output FIFO. Legal values are 2, 4 or 8 (power of two).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_data  input  WIDTH  word to route
- in_valid  input  1  producer offers in_data/select this cycle
- select  input  1  0 routes to out1, 1 routes to out2
- in_ready  output  1  selected FIFO can accept this cycle
- out1_data  output  WIDTH  head of FIFO 1
- out1_valid  output  1  FIFO 1 non-empty
- out1_ready  input  1  consumer 1 takes head this cycle
- out2_data  output  WIDTH  head of FIFO 2
- out2_valid  output  1  FIFO 2 non-empty
- out2_ready  input  1  consumer 2 takes head this cycle
- out1_count  output  4  FIFO 1 occupancy, 0..DEPTH
- out2_count  output  4  FIFO 2 occupancy, 0..DEPTH

Behaviour:
- All state changes on the rising edge of clk. rst is sampled only at that edge.

Reset:
- While rst=1 at an edge:
  - both FIFOs emptied; read and write pointers set to 0.
  - out1_count = out2_count = 0.
  - out1_valid = out2_valid = 0.
  - out1_data = out2_data = 0.
- in_ready = 0 while rst is high.
- Any push or pop presented in a reset cycle is discarded.
- Reset mid-stream drops all buffered words. No output is valid on the cycle after reset.

Push:
- in_ready = !rst && (select ? count2 != DEPTH : count1 != DEPTH). This is combinational from select and the registered counts.
- A push occurs when in_valid && in_ready at the edge.
- On a push, in_data is written at the tail of the FIFO chosen by select, and that tail pointer advances.
- select and in_data are don't-care when in_valid=0. select must not be X when in_valid=1.

Pop:
- outN_valid = (countN != 0).
- outN_data = storage[head], driven from registered state. It is stable while outN_valid && !outN_ready.
- A pop occurs when outN_valid && outN_ready at the edge; the head pointer advances.
- outN_ready while empty has no effect.

Latency:
- A word pushed at edge k appears at outN_data/outN_valid after edge k.
- There is no same-cycle bypass, even when the FIFO is empty.

Counts:
- Push only: count + 1. Pop only: count - 1. Push and pop on the same FIFO in one cycle: count unchanged, and both pointers advance.
- Full FIFO: in_ready = 0 for that select, even if the same cycle pops. There is no pass-through on full.

Other rules:
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Order is preserved per output. There is no ordering guarantee between out1 and out2.
- A push to FIFO 1 and a pop from FIFO 2 in the same cycle are independent.
- Occupancy never exceeds DEPTH and never underflows.

Test Plan:
- Reset/idle: assert rst for 2 edges with in_valid=1 -> counts 0, out1_valid = out2_valid = 0, out*_data = 0, in_ready = 0; in the first cycle after release, in_ready = 1.
- Routing: push 5 with select=0, then 9 with select=1, both outputs ready=0 -> out1_data=5, out2_data=9, each count=1; out1 shows 5 the cycle after its push edge.
- Fill/backpressure: with DEPTH=4 and out1_ready=0, push 1,2,3,4,5 with select=0 -> count1=4, in_ready=0 on the 5th; with select=1 in the same state, in_ready=1; word 5 is not stored.
- Drain and wrap: from the full state above, hold out1_ready=1 while pushing 6,7,8 -> out1 sequence 1,2,3,4,6,7,8 with no loss or duplication; count1 stays constant during simultaneous push/pop.
- Independent stall: out1_ready=1, out2_ready=0, alternate select 0/1 pushing 10..17 -> out1 drains 10,12,14,16; out2 holds 11 stable with count2 rising to 4; then in_ready=0 whenever select=1.
- Reset mid-operation: with count1=3 and count2=2, assert rst for one edge while in_valid=1 and out1_ready=1 -> next cycle both counts 0, both valids 0; a new push of 0 with select=1 then appears on out2 one cycle later.

Source files
------------

// File: rtl/demux_1to2_buffered.sv
// Registered 1-to-2 demultiplexer: routes one producer stream into one of two
// independent FIFOs, each with its own valid/ready consumer handshake.
module demux_1to2_buffered #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             select,
  output logic             in_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out2_data,
  output logic             out2_valid,
  input  logic             out2_ready,
  output logic [3:0]       out1_count,
  output logic [3:0]       out2_count
);

  localparam int         PW       = $clog2(DEPTH);
  localparam logic [3:0] FULL_CNT = 4'(DEPTH);

  logic [1:0]       full;
  logic [1:0]       push;
  logic [1:0]       pop;
  logic [1:0]       ready_vec;
  logic [3:0]       count [2];
  logic [WIDTH-1:0] head_data [2];

  assign ready_vec = {out2_ready, out1_ready};

  // A full FIFO refuses pushes even when it pops in the same cycle.
  assign in_ready = !rst && !full[select];

  for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [3:0]       count_q;
    logic [3:0]       count_d;

    assign full[gi]  = (count_q == FULL_CNT);
    assign push[gi]  = in_valid && in_ready && (select == 1'(gi));
    assign pop[gi]   = (count_q != 4'd0) && ready_vec[gi];
    assign count[gi] = count_q;

    always_comb begin
      count_d = count_q;
      case ({push[gi], pop[gi]})
        2'b10:   count_d = count_q + 4'd1;
        2'b01:   count_d = count_q - 4'd1;
        default: count_d = count_q;
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push[gi]) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop[gi])  rd_ptr_q <= rd_ptr_q + 1'b1;
        count_q <= count_d;
      end
    end

    // Storage has no reset so it can map onto RAM; push is already gated by rst.
    always_ff @(posedge clk) begin
      if (push[gi]) mem_q[wr_ptr_q] <= in_data;
    end

    assign head_data[gi] = (count_q != 4'd0) ? mem_q[rd_ptr_q] : '0;
  end

  assign out1_data  = head_data[0];
  assign out2_data  = head_data[1];
  assign out1_valid = (count[0] != 4'd0);
  assign out2_valid = (count[1] != 4'd0);
  assign out1_count = count[0];
  assign out2_count = count[1];

endmodule

// File: tb/tb_demux_1to2_buffered.sv
// Directed bench for demux_1to2_buffered: one task per scenario, inline checks
// against hand-computed values, one summary line at the end.
module tb_demux_1to2_buffered;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        select;
  logic        in_ready;
  logic [31:0] out1_data;
  logic        out1_valid;
  logic        out1_ready;
  logic [31:0] out2_data;
  logic        out2_valid;
  logic        out2_ready;
  logic [3:0]  out1_count;
  logic [3:0]  out2_count;

  int total = 0;
  int bad   = 0;

  demux_1to2_buffered #(.WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .select(select), .in_ready(in_ready),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
    .out2_data(out2_data), .out2_valid(out2_valid), .out2_ready(out2_ready),
    .out1_count(out1_count), .out2_count(out2_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One line per accepted transaction.
  always @(posedge clk) begin
    if (!rst && in_valid && in_ready)
      $display("push  sel=%0d data=%0d", select, in_data);
    if (!rst && out1_valid && out1_ready)
      $display("pop1  data=%0d", out1_data);
    if (!rst && out2_valid && out2_ready)
      $display("pop2  data=%0d", out2_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; select = 1'b0; in_data = 32'hAA;
    out1_ready = 1'b1; out2_ready = 1'b1;
    tick();
    tick();
    total++; if (out1_count !== 4'd0) begin bad++; $display("FAIL reset_count1 got=%0d exp=0", out1_count); end
    total++; if (out2_count !== 4'd0) begin bad++; $display("FAIL reset_count2 got=%0d exp=0", out2_count); end
    total++; if (out1_valid !== 1'b0 || out2_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b%b exp=00", out1_valid, out2_valid); end
    total++; if (out1_data !== 32'd0 || out2_data !== 32'd0) begin bad++; $display("FAIL reset_data got=%0h/%0h exp=0/0", out1_data, out2_data); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_routing();
    out1_ready = 1'b0; out2_ready = 1'b0;
    in_valid = 1'b1; select = 1'b0; in_data = 32'd5;
    #1;
    total++; if (out1_valid !== 1'b0) begin bad++; $display("FAIL route_no_bypass got=%b exp=0", out1_valid); end
    tick();
    total++; if (out1_valid !== 1'b1 || out1_data !== 32'd5) begin bad++; $display("FAIL route_out1 got=%b/%0d exp=1/5", out1_valid, out1_data); end
    total++; if (out2_valid !== 1'b0) begin bad++; $display("FAIL route_out2_idle got=%b exp=0", out2_valid); end
    select = 1'b1; in_data = 32'd9;
    tick();
    in_valid = 1'b0;
    total++; if (out2_valid !== 1'b1 || out2_data !== 32'd9) begin bad++; $display("FAIL route_out2 got=%b/%0d exp=1/9", out2_valid, out2_data); end
    total++; if (out1_count !== 4'd1 || out2_count !== 4'd1) begin bad++; $display("FAIL route_counts got=%0d/%0d exp=1/1", out1_count, out2_count); end
    total++; if (out1_data !== 32'd5) begin bad++; $display("FAIL route_out1_hold got=%0d exp=5", out1_data); end
    out1_ready = 1'b1; out2_ready = 1'b1;
    tick();
    out1_ready = 1'b0; out2_ready = 1'b0;
    total++; if (out1_count !== 4'd0 || out2_count !== 4'd0) begin bad++; $display("FAIL route_drain got=%0d/%0d exp=0/0", out1_count, out2_count); end
  endtask

  task automatic test_fill();
    out1_ready = 1'b0; out2_ready = 1'b0;
    in_valid = 1'b1; select = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_data = 32'(i);
      tick();
    end
    in_data = 32'd5;
    #1;
    total++; if (out1_count !== 4'd4) begin bad++; $display("FAIL fill_count got=%0d exp=4", out1_count); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fill_full_ready got=%b exp=0", in_ready); end
    select = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fill_other_ready got=%b exp=1", in_ready); end
    select = 1'b0;
    tick();
    total++; if (out1_count !== 4'd4 || out1_data !== 32'd1) begin bad++; $display("FAIL fill_no_store got=%0d/%0d exp=4/1", out1_count, out1_data); end
    total++; if (out2_count !== 4'd0) begin bad++; $display("FAIL fill_out2_empty got=%0d exp=0", out2_count); end
  endtask

  task automatic test_drain_wrap();
    int exp_d[7]     = '{1, 2, 3, 4, 6, 7, 8};
    int exp_cnt[7]   = '{3, 3, 3, 3, 2, 1, 0};
    bit exp_rdy[7]   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    int src[3]       = '{6, 7, 8};
    int idx          = 0;
    out1_ready = 1'b1; select = 1'b0;
    for (int k = 0; k < 7; k++) begin
      in_valid = (idx < 3);
      in_data  = (idx < 3) ? 32'(src[idx]) : 32'd0;
      #1;
      total++; if (out1_valid !== 1'b1 || out1_data !== 32'(exp_d[k])) begin bad++; $display("FAIL wrap_data[%0d] got=%b/%0d exp=1/%0d", k, out1_valid, out1_data, exp_d[k]); end
      total++; if (in_ready !== exp_rdy[k]) begin bad++; $display("FAIL wrap_ready[%0d] got=%b exp=%b", k, in_ready, exp_rdy[k]); end
      if (in_valid && in_ready) idx++;
      tick();
      total++; if (out1_count !== 4'(exp_cnt[k])) begin bad++; $display("FAIL wrap_count[%0d] got=%0d exp=%0d", k, out1_count, exp_cnt[k]); end
    end
    in_valid = 1'b0; out1_ready = 1'b0;
    total++; if (out1_valid !== 1'b0) begin bad++; $display("FAIL wrap_empty got=%b exp=0", out1_valid); end
  endtask

  task automatic test_independent_stall();
    out1_ready = 1'b1; out2_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      select  = 1'(i % 2);
      in_data = 32'(10 + i);
      #1;
      if (i % 2 == 1) begin
        total++; if (out1_valid !== 1'b1 || out1_data !== 32'(9 + i)) begin bad++; $display("FAIL stall_out1[%0d] got=%b/%0d exp=1/%0d", i, out1_valid, out1_data, 9 + i); end
      end
      if (i >= 2) begin
        total++; if (out2_data !== 32'd11) begin bad++; $display("FAIL stall_out2_hold[%0d] got=%0d exp=11", i, out2_data); end
      end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_ready[%0d] got=%b exp=1", i, in_ready); end
      tick();
      total++; if (out2_count !== 4'((i + 1) / 2)) begin bad++; $display("FAIL stall_count2[%0d] got=%0d exp=%0d", i, out2_count, (i + 1) / 2); end
    end
    in_valid = 1'b0;
    total++; if (out1_count !== 4'd0) begin bad++; $display("FAIL stall_count1 got=%0d exp=0", out1_count); end
    select = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_full2_ready got=%b exp=0", in_ready); end
    select = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_sel0_ready got=%b exp=1", in_ready); end
    out2_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (out2_data !== 32'(11 + 2 * i)) begin bad++; $display("FAIL stall_drain2[%0d] got=%0d exp=%0d", i, out2_data, 11 + 2 * i); end
      tick();
    end
    out2_ready = 1'b0;
    total++; if (out2_count !== 4'd0) begin bad++; $display("FAIL stall_drained got=%0d exp=0", out2_count); end
  endtask

  task automatic test_mid_reset();
    bit sel_seq[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    out1_ready = 1'b0; out2_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      select  = sel_seq[i];
      in_data = 32'(20 + i);
      tick();
    end
    total++; if (out1_count !== 4'd3 || out2_count !== 4'd2) begin bad++; $display("FAIL mid_prefill got=%0d/%0d exp=3/2", out1_count, out2_count); end
    rst = 1'b1; out1_ready = 1'b1; select = 1'b0; in_data = 32'd99;
    tick();
    rst = 1'b0; in_valid = 1'b0; out1_ready = 1'b0;
    total++; if (out1_count !== 4'd0 || out2_count !== 4'd0) begin bad++; $display("FAIL mid_counts got=%0d/%0d exp=0/0", out1_count, out2_count); end
    total++; if (out1_valid !== 1'b0 || out2_valid !== 1'b0) begin bad++; $display("FAIL mid_valids got=%b%b exp=00", out1_valid, out2_valid); end
    in_valid = 1'b1; select = 1'b1; in_data = 32'd0;
    #1;
    total++; if (out2_valid !== 1'b0) begin bad++; $display("FAIL mid_no_bypass got=%b exp=0", out2_valid); end
    tick();
    in_valid = 1'b0;
    total++; if (out2_valid !== 1'b1 || out2_data !== 32'd0 || out2_count !== 4'd1) begin bad++; $display("FAIL mid_repush got=%b/%0d/%0d exp=1/0/1", out2_valid, out2_data, out2_count); end
    total++; if (out1_valid !== 1'b0) begin bad++; $display("FAIL mid_out1_idle got=%b exp=0", out1_valid); end
  endtask

  initial begin
    rst = 1'b1; in_data = '0; in_valid = 1'b0; select = 1'b0;
    out1_ready = 1'b0; out2_ready = 1'b0;
    test_reset();
    test_routing();
    test_fill();
    test_drain_wrap();
    test_independent_stall();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
